receptor_ctrl: RTL
==================

# receptor_ctrl

Per-lane sequencer for the four receptors: left, down, up and right.

- Converts the single USB keycode byte into per-lane press/hold/release state.
- Times the receptor flash and fade against the frame tick.
- Emits one-cycle press/release events for the judgement logic.
- Sits between the keyboard keycode register and the receptor drawing and colour-mapping logic, replacing raw keycode compares with registered, frame-timed lane state.

## Interface

Parameters:
- KEY_LEFT, 8'h34, keycode for lane 0
- KEY_DOWN, 8'h33, keycode for lane 1
- KEY_UP, 8'h35, keycode for lane 2
- KEY_RIGHT, 8'h3b, keycode for lane 3
- FLASH_FRAMES, 4, frames a lane stays in PRESS (bright flash) before HELD; range 1..15
- FADE_FRAMES, 2, frames a lane stays lit after release; range 1..15

Ports:
- Clk  input  1  system clock; all state on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- keycode  input  8  current keycode; 8'h00 or any unmapped value means no key
- frame_clk  input  1  frame strobe (vsync-derived), asynchronous to Clk
- lit  output  4  lane drawn in pressed colour (PRESS, HELD or FADE)
- flash  output  4  lane in PRESS (bright variant)
- held  output  4  lane in HELD
- press_event  output  4  one-cycle pulse on entry to PRESS
- release_event  output  4  one-cycle pulse on leaving PRESS/HELD due to key release

## Operation

- keycode is registered into kc_q every cycle. key_match[i] = (kc_q == KEY_i), so at most one lane matches at a time.
- frame_clk passes through a 2-flop synchronizer. A rising-edge detect produces a one-cycle tick.
- Each lane has an independent FSM with a 4-bit frame counter cnt.
  - IDLE: if key_match, go to PRESS, load cnt = FLASH_FRAMES, pulse press_event.
  - PRESS: if !key_match, go to FADE, load cnt = FADE_FRAMES, pulse release_event. Else, on tick, cnt decrements; on a tick with cnt == 1, go to HELD.
  - HELD: if !key_match, go to FADE, load cnt = FADE_FRAMES, pulse release_event.
  - FADE: if key_match, go to PRESS, load cnt = FLASH_FRAMES, pulse press_event. Else, on tick, cnt decrements; on a tick with cnt == 1, go to IDLE.
- Priority rules:
  - Release beats the final tick in PRESS.
  - Re-press beats the final tick in FADE.
- Keycode switching directly from lane A to lane B in one cycle: A leaves (release_event[A]) and B enters PRESS (press_event[B]) on the same edge.
- Outputs are registered and decoded from the state register:
  - lit = state != IDLE
  - flash = state == PRESS
  - held = state == HELD
- Event pulses are registered, high for exactly one cycle, and never asserted in back-to-back cycles for the same lane.

## Timing

- Reset (Reset_n low, asynchronous) forces the following, held until the first rising Clk edge after deassertion:
  - all lanes IDLE, cnt = 0
  - kc_q = 8'h00
  - sync flops and the edge-detect register = 0
  - all outputs 0
- Press latency: keycode valid before edge k means kc_q updates at edge k, and state, press_event, lit and flash update at edge k+1. That is 2 cycles input to output.
- Release latency is identical: 2 cycles.
- Tick latency:
  - frame_clk rising before edge k means the tick is high in the cycle after edge k+2.
  - cnt updates and state changes occur at edge k+3.
- PRESS duration:
  - A press entered mid-frame spends FLASH_FRAMES ticks in PRESS.
  - The first partial frame does not count; the count is in whole ticks seen.
- Reset asserted mid-operation:
  - All lanes go to IDLE immediately, with no release_event.
  - A key still held at deassertion produces press_event 2 cycles later.
- Counter never wraps. cnt is only decremented while nonzero, in PRESS or FADE.

## Test plan

1. Reset with keycode = 8'h34 held; release Reset_n → press_event = 4'b0001 exactly 2 cycles after first edge, lit = flash = 4'b0001; no event during reset.
2. FLASH_FRAMES = 4: hold 8'h33 across 5 frame_clk edges → flash[1] high for exactly 4 ticks, then held[1] = 1, flash[1] = 0, lit[1] stays 1; no further events.
3. FADE_FRAMES = 2: from HELD on lane 3, set keycode = 8'h00 → release_event = 4'b1000 one cycle, lit[3] high for 2 more ticks, then 0.
4. Re-press in FADE coinciding with the final tick → lane goes to PRESS (flash = 1, press_event pulse), never IDLE; lit never drops.
5. keycode 8'h34 → 8'h35 in one cycle → release_event = 4'b0001 and press_event = 4'b0100 on the same cycle; lanes 0 and 2 both lit while lane 0 fades.
6. Unmapped keycode 8'h1c for 10 frames, and frame_clk toggling asynchronously → all outputs remain 0; exactly one tick per frame_clk rising edge (count ticks).

Source files
------------

// File: rtl/receptor_ctrl.sv
// receptor_ctrl: per-lane press/hold/fade sequencer for the four receptors.
// Ports: Clk, Reset_n, keycode, frame_clk in; lit/flash/held/press_event/release_event out (one bit per lane).
module receptor_ctrl #(
  parameter logic [7:0] KEY_LEFT     = 8'h34,
  parameter logic [7:0] KEY_DOWN     = 8'h33,
  parameter logic [7:0] KEY_UP       = 8'h35,
  parameter logic [7:0] KEY_RIGHT    = 8'h3b,
  parameter int unsigned FLASH_FRAMES = 4,
  parameter int unsigned FADE_FRAMES  = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_clk,
  output logic [3:0] lit,
  output logic [3:0] flash,
  output logic [3:0] held,
  output logic [3:0] press_event,
  output logic [3:0] release_event
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_HELD,
    S_FADE
  } state_t;

  localparam logic [3:0] FLASH_LD = 4'(FLASH_FRAMES);
  localparam logic [3:0] FADE_LD  = 4'(FADE_FRAMES);

  logic [7:0] r_kc_q;
  logic [1:0] r_sync;
  logic       r_sync_d;
  logic       r_tick;
  logic [3:0] w_match;

  // frame_clk is asynchronous: two-flop sync, then a registered
  // rising-edge detect gives one tick per frame.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_kc_q   <= 8'h00;
      r_sync   <= 2'b00;
      r_sync_d <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_kc_q   <= keycode;
      r_sync   <= {r_sync[0], frame_clk};
      r_sync_d <= r_sync[1];
      r_tick   <= r_sync[1] & ~r_sync_d;
    end
  end

  assign w_match = {
    r_kc_q == KEY_RIGHT,
    r_kc_q == KEY_UP,
    r_kc_q == KEY_DOWN,
    r_kc_q == KEY_LEFT
  };

  for (genvar g = 0; g < 4; g++) begin : g_lane
    state_t     r_st;
    state_t     w_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_pe;
    logic       w_re;
    logic       w_dec;
    logic       r_lit;
    logic       r_flash;
    logic       r_held;
    logic       r_pe;
    logic       r_re;

    // Counter only moves on a tick while nonzero, so it never wraps.
    assign w_dec = r_tick && (r_cnt != 4'd0);

    always_comb begin
      w_nxt     = r_st;
      w_cnt_nxt = r_cnt;
      w_pe      = 1'b0;
      w_re      = 1'b0;
      unique case (r_st)
        S_IDLE: begin
          if (w_match[g]) begin
            w_nxt     = S_PRESS;
            w_cnt_nxt = FLASH_LD;
            w_pe      = 1'b1;
          end
        end
        S_PRESS: begin
          // release wins over the final flash tick
          if (!w_match[g]) begin
            w_nxt     = S_FADE;
            w_cnt_nxt = FADE_LD;
            w_re      = 1'b1;
          end else if (w_dec) begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_nxt = S_HELD;
          end
        end
        S_HELD: begin
          if (!w_match[g]) begin
            w_nxt     = S_FADE;
            w_cnt_nxt = FADE_LD;
            w_re      = 1'b1;
          end
        end
        S_FADE: begin
          // re-press wins over the final fade tick
          if (w_match[g]) begin
            w_nxt     = S_PRESS;
            w_cnt_nxt = FLASH_LD;
            w_pe      = 1'b1;
          end else if (w_dec) begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) w_nxt = S_IDLE;
          end
        end
        default: begin
          w_nxt     = S_IDLE;
          w_cnt_nxt = 4'd0;
        end
      endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        r_st    <= S_IDLE;
        r_cnt   <= 4'd0;
        r_lit   <= 1'b0;
        r_flash <= 1'b0;
        r_held  <= 1'b0;
        r_pe    <= 1'b0;
        r_re    <= 1'b0;
      end else begin
        r_st    <= w_nxt;
        r_cnt   <= w_cnt_nxt;
        r_lit   <= (w_nxt != S_IDLE);
        r_flash <= (w_nxt == S_PRESS);
        r_held  <= (w_nxt == S_HELD);
        r_pe    <= w_pe;
        r_re    <= w_re;
      end
    end

    assign lit[g]           = r_lit;
    assign flash[g]         = r_flash;
    assign held[g]          = r_held;
    assign press_event[g]   = r_pe;
    assign release_event[g] = r_re;
  end

endmodule
